rotate_point_pipe: RTL and testbench

Pipelined, parametrised rotation unit for the rotated-BRIEF stage. It rotates one pattern point per cycle by a keypoint orientation: out_x = px·cos − py·sin and out_y = px·sin + py·cos. The result is rounded or truncated, then saturated to the output width. It adds a 3-stage registered datapath, a valid/ready handshake with full backpressure, a saturation flag, and a per-keypoint point counter with last marker. It sits between the orientation/cos-sin lookup and the pixel-pair fetch for the binary descriptor.

---
 rtl/rotate_point_pipe.sv | 114 +++++++++++
 tb/tb_rotate_point_pipe.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotate_point_pipe.sv
// Rotates one pattern point per beat by (cos, sin), with rounding and saturation to OBW.
// Latency 3 cycles, 1 beat/cycle; a stalled output freezes every stage (in_ready = out_ready | ~out_valid).
module rotate_point_pipe #(
  parameter int PBW   = 6,
  parameter int CBW   = 9,
  parameter int CFRAC = 7,
  parameter int OBW   = 6,
  parameter int RND   = 1,
  parameter int NPTS  = 512,
  localparam int IW   = (NPTS > 1) ? $clog2(NPTS) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [PBW-1:0] in_px,
  input  logic [PBW-1:0] in_py,
  input  logic [CBW-1:0] in_cos,
  input  logic [CBW-1:0] in_sin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [OBW-1:0] out_x,
  output logic [OBW-1:0] out_y,
  output logic           out_sat,
  output logic [IW-1:0]  out_idx,
  output logic           out_last
);

  localparam int PW = PBW + CBW;
  localparam int SW = PW + 1;
  localparam logic signed [SW:0] RC   = (RND != 0) ? (SW+1)'(2**(CFRAC-1)) : '0;
  localparam logic signed [SW:0] OMAX = (SW+1)'(2**(OBW-1) - 1);
  localparam logic signed [SW:0] OMIN = (SW+1)'(-(2**(OBW-1)));
  localparam logic [IW-1:0] LASTIDX   = IW'(NPTS - 1);

  logic en;
  logic v1, v2, v3;
  logic signed [PBW-1:0] spx, spy;
  logic signed [CBW-1:0] scos, ssin;
  logic signed [PW-1:0]  p_xc, p_ys, p_xs, p_yc;
  logic signed [SW-1:0]  sx, sy;
  logic [OBW:0]          rx, ry;
  logic signed [OBW-1:0] x_q, y_q;
  logic                  sat_q;
  logic [IW-1:0]         cnt;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  assign spx  = in_px;
  assign spy  = in_py;
  assign scos = in_cos;
  assign ssin = in_sin;

  // Returns {clipped, value}: round per RND, floor-shift by CFRAC, clamp to OBW.
  function automatic logic [OBW:0] scale(input logic signed [SW-1:0] s);
    logic signed [SW:0] r;
    logic signed [SW:0] q;
    r = (SW+1)'(s) + RC;
    q = r >>> CFRAC;
    if (q > OMAX)      scale = {1'b1, OMAX[OBW-1:0]};
    else if (q < OMIN) scale = {1'b1, OMIN[OBW-1:0]};
    else               scale = {1'b0, q[OBW-1:0]};
  endfunction

  always_comb begin
    rx = scale(sx);
    ry = scale(sy);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1    <= 1'b0;
      v2    <= 1'b0;
      v3    <= 1'b0;
      p_xc  <= '0;
      p_ys  <= '0;
      p_xs  <= '0;
      p_yc  <= '0;
      sx    <= '0;
      sy    <= '0;
      x_q   <= '0;
      y_q   <= '0;
      sat_q <= 1'b0;
      cnt   <= '0;
    end else begin
      if (en) begin
        v1    <= in_valid;
        p_xc  <= PW'(spx) * PW'(scos);
        p_ys  <= PW'(spy) * PW'(ssin);
        p_xs  <= PW'(spx) * PW'(ssin);
        p_yc  <= PW'(spy) * PW'(scos);
        v2    <= v1;
        sx    <= SW'(p_xc) - SW'(p_ys);
        sy    <= SW'(p_xs) + SW'(p_yc);
        v3    <= v2;
        x_q   <= rx[OBW-1:0];
        y_q   <= ry[OBW-1:0];
        sat_q <= rx[OBW] | ry[OBW];
      end
      // The counter names the beat at the output, so it moves only on a completed handshake.
      if (v3 && out_ready)
        cnt <= (cnt == LASTIDX) ? '0 : cnt + IW'(1);
    end
  end

  assign out_valid = v3;
  assign out_x     = x_q;
  assign out_y     = y_q;
  assign out_sat   = sat_q;
  assign out_idx   = cnt;
  assign out_last  = v3 & (cnt == LASTIDX);

endmodule

// File: tb/tb_rotate_point_pipe.sv
// Scoreboard bench: two instances (RND=1 and RND=0, both NPTS=4) share one stimulus stream.
module tb_rotate_point_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, out_ready;
  logic [5:0] in_px, in_py;
  logic [8:0] in_cos, in_sin;
  logic       a_in_ready, a_out_valid, a_out_sat, a_out_last;
  logic       b_in_ready, b_out_valid, b_out_sat, b_out_last;
  logic [5:0] a_out_x, a_out_y, b_out_x, b_out_y;
  logic [1:0] a_out_idx, b_out_idx;

  rotate_point_pipe #(.PBW(6), .CBW(9), .CFRAC(7), .OBW(6), .RND(1), .NPTS(4)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_px(in_px), .in_py(in_py), .in_cos(in_cos), .in_sin(in_sin),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_x(a_out_x), .out_y(a_out_y),
    .out_sat(a_out_sat), .out_idx(a_out_idx), .out_last(a_out_last));

  rotate_point_pipe #(.PBW(6), .CBW(9), .CFRAC(7), .OBW(6), .RND(0), .NPTS(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_px(in_px), .in_py(in_py), .in_cos(in_cos), .in_sin(in_sin),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_x(b_out_x), .out_y(b_out_y),
    .out_sat(b_out_sat), .out_idx(b_out_idx), .out_last(b_out_last));

  typedef struct {
    int x1; int y1; int s1;
    int x0; int y0; int s0;
    int idx; bit chk_lat; int acc;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;
  int   checks = 0, errors = 0, cyc = 0, acc_cnt = 0;
  int   cx1, cy1, cs1, cx0, cy0, cs0;
  bit   cur_lat = 1'b0, first_after_rst = 1'b0, rnd_ready = 1'b0, stalled = 1'b0;
  logic [5:0] hx, hy;
  logic       hsat;
  logic [1:0] hidx;

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d want %0d", nm, got, want);
    end
  endtask

  // Reference: exact integer rotation, round-half-up or floor, then clamp to [-32, 31].
  function automatic void rot(input int px, input int py, input int c, input int s,
                              input bit rnd, output int x, output int y, output int sat);
    int sx, sy;
    sx = px * c - py * s;
    sy = px * s + py * c;
    if (rnd) begin
      sx += 64;
      sy += 64;
    end
    sx = sx >>> 7;
    sy = sy >>> 7;
    sat = 0;
    if (sx > 31) begin x = 31; sat = 1; end else if (sx < -32) begin x = -32; sat = 1; end else x = sx;
    if (sy > 31) begin y = 31; sat = 1; end else if (sy < -32) begin y = -32; sat = 1; end else y = sy;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      qa.delete();
      qb.delete();
      acc_cnt = 0;
      stalled = 1'b0;
    end else begin
      if (a_out_valid && out_ready) begin
        if (qa.size() == 0) check("a_unexpected_beat", 1, 0);
        else begin
          ea = qa.pop_front();
          check("a_x", int'($signed(a_out_x)), ea.x1);
          check("a_y", int'($signed(a_out_y)), ea.y1);
          check("a_sat", int'(a_out_sat), ea.s1);
          check("a_idx", int'(a_out_idx), ea.idx);
          check("a_last", int'(a_out_last), int'(ea.idx == 3));
          if (ea.chk_lat) check("latency", cyc - ea.acc, 3);
          if (first_after_rst) begin
            check("idx_after_rst", int'(a_out_idx), 0);
            first_after_rst = 1'b0;
          end
        end
      end
      if (b_out_valid && out_ready) begin
        if (qb.size() == 0) check("b_unexpected_beat", 1, 0);
        else begin
          eb = qb.pop_front();
          check("b_x", int'($signed(b_out_x)), eb.x0);
          check("b_y", int'($signed(b_out_y)), eb.y0);
          check("b_sat", int'(b_out_sat), eb.s0);
          check("b_idx", int'(b_out_idx), eb.idx);
          check("b_last", int'(b_out_last), int'(eb.idx == 3));
        end
      end
      if (stalled) begin
        check("stall_valid", int'(a_out_valid), 1);
        check("stall_x", int'(a_out_x), int'(hx));
        check("stall_y", int'(a_out_y), int'(hy));
        check("stall_sat", int'(a_out_sat), int'(hsat));
        check("stall_idx", int'(a_out_idx), int'(hidx));
      end
      if (a_out_valid && !out_ready) begin
        check("a_in_ready_stall", int'(a_in_ready), 0);
        check("b_in_ready_stall", int'(b_in_ready), 0);
        stalled = 1'b1;
        hx = a_out_x; hy = a_out_y; hsat = a_out_sat; hidx = a_out_idx;
      end else stalled = 1'b0;
      if (in_valid && a_in_ready) begin
        ea = '{x1: cx1, y1: cy1, s1: cs1, x0: cx0, y0: cy0, s0: cs0,
               idx: acc_cnt % 4, chk_lat: cur_lat, acc: cyc};
        qa.push_back(ea);
        qb.push_back(ea);
        acc_cnt++;
      end
    end
  end

  // Randomised downstream readiness, applied just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
  end

  task automatic drive(input int px, input int py, input int c, input int s);
    in_px = px[5:0];
    in_py = py[5:0];
    in_cos = c[8:0];
    in_sin = s[8:0];
    in_valid = 1'b1;
  endtask

  task automatic wait_accept();
    bit acc;
    acc = 1'b0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      acc = a_in_ready;
      @(posedge clk);
      #1;
      if (acc) break;
    end
    if (!acc) check("accept_timeout", 1, 0);
  endtask

  task automatic send_dir(input int px, input int py, input int c, input int s,
                          input int x1, input int y1, input int s1,
                          input int x0, input int y0, input int s0);
    cx1 = x1; cy1 = y1; cs1 = s1; cx0 = x0; cy0 = y0; cs0 = s0;
    drive(px, py, c, s);
    wait_accept();
  endtask

  task automatic send_rand();
    int px, py, c, s;
    px = int'($urandom_range(0, 63)) - 32;
    py = int'($urandom_range(0, 63)) - 32;
    c  = int'($urandom_range(0, 511)) - 256;
    s  = int'($urandom_range(0, 511)) - 256;
    rot(px, py, c, s, 1'b1, cx1, cy1, cs1);
    rot(px, py, c, s, 1'b0, cx0, cy0, cs0);
    drive(px, py, c, s);
    wait_accept();
  endtask

  task automatic drain();
    int n;
    in_valid = 1'b0;
    rnd_ready = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 100) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_a_empty", qa.size(), 0);
    check("drain_b_empty", qb.size(), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    in_px = '0; in_py = '0; in_cos = '0; in_sin = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(a_out_valid), 0);
    check("rst_out_x", int'(a_out_x), 0);
    check("rst_out_y", int'(a_out_y), 0);
    check("rst_out_sat", int'(a_out_sat), 0);
    check("rst_out_idx", int'(a_out_idx), 0);
    check("rst_out_last", int'(a_out_last), 0);
    check("rst_in_ready", int'(a_in_ready), 1);
    check("rst_b_out_valid", int'(b_out_valid), 0);
    @(posedge clk);
    #1;

    // Directed points, back to back with no stall; nine beats exercise the NPTS=4 wrap.
    cur_lat = 1'b1;
    send_dir(5, -3, 128, 0,    5, -3, 0,   5, -3, 0);
    send_dir(5, -3, 0, 128,    3,  5, 0,   3,  5, 0);
    send_dir(10, 0, 91, 91,    7,  7, 0,   7,  7, 0);
    send_dir(-1, 0, 64, 0,     0,  0, 0,  -1,  0, 0);
    send_dir(31, 31, 91, 91,   0, 31, 1,   0, 31, 1);
    send_dir(-31, -31, 91, 91, 0, -32, 1,  0, -32, 1);
    repeat (3) send_rand();
    in_valid = 1'b0;
    drain();
    cur_lat = 1'b0;

    // Reset with beats in flight.
    repeat (6) send_rand();
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    first_after_rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", int'(a_out_valid), 0);
    check("midrst_out_idx", int'(a_out_idx), 0);
    @(posedge clk);
    #1;
    repeat (3) send_rand();
    drain();
    check("idx_after_rst_seen", int'(first_after_rst), 0);

    // Continuous stream with a five-cycle downstream stall.
    fork
      begin
        repeat (14) send_rand();
        in_valid = 1'b0;
      end
      begin
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random traffic with random bubbles and backpressure.
    rnd_ready = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      send_rand();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
